// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, ALU classes and control bundle for the decode stage
package decode_pkg;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_LW    = 4'd1;
    localparam logic [3:0] OP_SW    = 4'd2;
    localparam logic [3:0] OP_BEQ   = 4'd3;
    localparam logic [3:0] OP_ADDI  = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OR     = 2'b11;

    typedef struct packed {
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Unlisted opcodes decode to an all-zero bundle, i.e. a NOP.
    function automatic ctrl_t decode_ctrl(input logic [3:0] op);
        ctrl_t c;
        c = CTRL_NONE;
        case (op)
            OP_RTYPE: begin c.regwrite = 1'b1; c.aluop = ALU_RTYPE; end
            OP_LW: begin
                c.memread  = 1'b1;
                c.memtoreg = 1'b1;
                c.alusrc   = 1'b1;
                c.regwrite = 1'b1;
                c.aluop    = ALU_ADD;
            end
            OP_SW:   begin c.memwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALU_ADD; end
            OP_BEQ:  begin c.aluop = ALU_BRANCH; end
            OP_ADDI: begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = ALU_ADD; end
            OP_ORI:  begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = ALU_OR; end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 2R1W register file with write-first bypass and hardwired r0
module decode_regfile #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] regs_q [NREG];

    // Write port; entry 0 is never written so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we && waddr != '0) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Read port 1: r0 reads zero, a same-cycle write to the address wins over storage.
    always_comb begin
        if (raddr1 == '0)                 rdata1 = '0;
        else if (we && waddr == raddr1)   rdata1 = wdata;
        else                              rdata1 = regs_q[raddr1];
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        if (raddr2 == '0)                 rdata2 = '0;
        else if (we && waddr == raddr2)   rdata2 = wdata;
        else                              rdata2 = regs_q[raddr2];
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode, load-use hazard stall and ID/EX register
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    output logic              id_ready,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_memread,
    output logic              ex_memtoreg,
    output logic              ex_memwrite,
    output logic              ex_alusrc,
    output logic              ex_regwrite,
    output logic [1:0]        ex_aluop,
    output logic [15:0]       stall_cnt
);

    logic [3:0]        op;
    logic [REG_AW-1:0] rd, rs, rt;
    logic [DATA_W-1:0] rdata1, rdata2, imm_ext;
    ctrl_t             ctrl;
    logic              uses_rt, hazard, stall, load_bubble;

    logic              ex_valid_q;
    ctrl_t             ex_ctrl_q;
    logic [DATA_W-1:0] ex_rd1_q, ex_rd2_q, ex_imm_q;
    logic [REG_AW-1:0] ex_rs_q, ex_rt_q, ex_rd_q;
    logic [15:0]       stall_cnt_q;

    assign op = if_instr[31:28];
    assign rd = REG_AW'(if_instr[27:24]);
    assign rs = REG_AW'(if_instr[23:20]);
    assign rt = REG_AW'(if_instr[19:16]);

    decode_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    // Decode control bits and extend the immediate (ORI alone zero-extends).
    always_comb begin
        ctrl = decode_ctrl(op);
        if (op == OP_ORI) imm_ext = DATA_W'(if_instr[IMM_W-1:0]);
        else              imm_ext = DATA_W'($signed(if_instr[IMM_W-1:0]));
    end

    // Load-use hazard: rt only matters for instructions that actually read it.
    always_comb begin
        uses_rt     = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
        hazard      = ex_valid_q && ex_ctrl_q.memread && (ex_rd_q != '0) &&
                      ((ex_rd_q == rs) || ((ex_rd_q == rt) && uses_rt));
        stall       = hazard && if_valid && !flush;
        load_bubble = flush || !if_valid || stall;
        id_ready    = !stall;
    end

    // ID/EX pipeline register; a bubble clears every field so nothing stale leaks forward.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || load_bubble) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= CTRL_NONE;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_imm_q   <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
        end else begin
            ex_valid_q <= 1'b1;
            ex_ctrl_q  <= ctrl;
            ex_rd1_q   <= rdata1;
            ex_rd2_q   <= rdata2;
            ex_imm_q   <= imm_ext;
            ex_rs_q    <= rs;
            ex_rt_q    <= rt;
            ex_rd_q    <= rd;
        end
    end

    // Saturating count of cycles spent stalled on a load-use hazard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               stall_cnt_q <= '0;
        else if (stall && stall_cnt_q != '1)    stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign ex_valid    = ex_valid_q;
    assign ex_rd1      = ex_rd1_q;
    assign ex_rd2      = ex_rd2_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rs       = ex_rs_q;
    assign ex_rt       = ex_rt_q;
    assign ex_rd       = ex_rd_q;
    assign ex_memread  = ex_ctrl_q.memread;
    assign ex_memtoreg = ex_ctrl_q.memtoreg;
    assign ex_memwrite = ex_ctrl_q.memwrite;
    assign ex_alusrc   = ex_ctrl_q.alusrc;
    assign ex_regwrite = ex_ctrl_q.regwrite;
    assign ex_aluop    = ex_ctrl_q.aluop;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage against a reference model
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        id_ready;
    logic        flush;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_rd1, ex_rd2, ex_imm;
    logic [3:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
    logic [1:0]  ex_aluop;
    logic [15:0] stall_cnt;

    decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .id_ready    (id_ready),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .ex_valid    (ex_valid),
        .ex_rd1      (ex_rd1),
        .ex_rd2      (ex_rd2),
        .ex_imm      (ex_imm),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_rd       (ex_rd),
        .ex_memread  (ex_memread),
        .ex_memtoreg (ex_memtoreg),
        .ex_memwrite (ex_memwrite),
        .ex_alusrc   (ex_alusrc),
        .ex_regwrite (ex_regwrite),
        .ex_aluop    (ex_aluop),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: {memread,memtoreg,memwrite,alusrc,regwrite,aluop[1:0]} per opcode.
    logic [6:0]  ctrl_table [16];
    logic [31:0] m_regs [16];
    bit          m_valid;
    logic [6:0]  m_ctrl;
    logic [3:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_rd1, m_rd2, m_imm;
    int          m_stalls;
    bit          last_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt, input int imm);
        mk = {op[3:0], rd[3:0], rs[3:0], rt[3:0], imm[15:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_valid = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_rd = 0;
        m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_stalls = 0; last_stall = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a, input bit we,
                                                input logic [3:0] wa, input logic [31:0] wd);
        if (a == 0)              return 0;
        else if (we && wa == a)  return wd;
        else                     return m_regs[a];
    endfunction

    task automatic check_outputs();
        check("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
        check("ex_ctrl", {25'b0, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_aluop},
              {25'b0, m_ctrl});
        check("stall_cnt", {16'b0, stall_cnt}, m_stalls);
        if (m_valid) begin
            check("ex_rd1", ex_rd1, m_rd1);
            check("ex_rd2", ex_rd2, m_rd2);
            check("ex_imm", ex_imm, m_imm);
            check("ex_regs", {20'b0, ex_rs, ex_rt, ex_rd}, {20'b0, m_rs, m_rt, m_rd});
        end
    endtask

    // One pipeline cycle: drive at negedge, check id_ready before the edge, check ex_* after it.
    task automatic step(input bit v, input logic [31:0] ins, input bit fl,
                        input bit we, input logic [3:0] wa, input logic [31:0] wd);
        logic [3:0]  op, rd, rs, rt;
        logic [31:0] imm, n_rd1, n_rd2;
        bit          haz, stall;
        @(negedge clk);
        if_valid = v; if_instr = ins; flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
        op = ins[31:28]; rd = ins[27:24]; rs = ins[23:20]; rt = ins[19:16];
        haz   = m_valid && m_ctrl[6] && m_rd != 0 &&
                (m_rd == rs || (m_rd == rt && (op == 0 || op == 2 || op == 3)));
        stall = haz && v && !fl;
        check("id_ready", {31'b0, id_ready}, {31'b0, !stall});
        imm = {16'b0, ins[15:0]};
        if (op != 5 && ins[15]) imm = imm | 32'hFFFF_0000;
        n_rd1 = model_read(rs, we, wa, wd);
        n_rd2 = model_read(rt, we, wa, wd);
        @(posedge clk);
        if (we && wa != 0) m_regs[wa] = wd;
        if (stall && m_stalls < 16'hFFFF) m_stalls++;
        if (fl || !v || stall) begin
            m_valid = 0; m_ctrl = 0;
        end else begin
            m_valid = 1; m_ctrl = ctrl_table[op];
            m_rs = rs; m_rt = rt; m_rd = rd;
            m_rd1 = n_rd1; m_rd2 = n_rd2; m_imm = imm;
        end
        last_stall = stall;
        #1;
        check_outputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ins;
        bit          v, fl, we;

        for (int i = 0; i < 16; i++) ctrl_table[i] = 7'b0;
        ctrl_table[0] = 7'b0000110;
        ctrl_table[1] = 7'b1101100;
        ctrl_table[2] = 7'b0011000;
        ctrl_table[3] = 7'b0000001;
        ctrl_table[4] = 7'b0001100;
        ctrl_table[5] = 7'b0001111;
        model_reset();

        rst = 1'b0; if_valid = 0; if_instr = 0; flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ex_valid", {31'b0, ex_valid}, 0);
        check("reset_stall_cnt", {16'b0, stall_cnt}, 0);
        check("reset_ex_imm", ex_imm, 0);
        check("reset_id_ready", {31'b0, id_ready}, 1);
        @(negedge clk);
        rst = 1'b1;

        // ADDI r1, imm 0xFFFF accepted on the first edge after reset release
        step(1, mk(4, 1, 0, 0, 16'hFFFF), 0, 0, 0, 0);
        check("addi_imm", ex_imm, 32'hFFFF_FFFF);
        check("addi_rd", {28'b0, ex_rd}, 1);
        check("addi_ctrl", {30'b0, ex_alusrc, ex_regwrite}, 3);

        // ORI zero-extends
        step(1, mk(5, 2, 0, 0, 16'h8000), 0, 0, 0, 0);
        check("ori_imm", ex_imm, 32'h0000_8000);
        check("ori_aluop", {30'b0, ex_aluop}, 3);

        // Write-first bypass, and r0 stays zero
        step(1, mk(0, 4, 3, 0, 0), 0, 1, 3, 32'h1234);
        check("bypass_rd1", ex_rd1, 32'h1234);
        step(1, mk(0, 5, 0, 3, 0), 0, 1, 0, 32'hDEAD);
        check("r0_read", ex_rd1, 0);

        // Load-use stall: LW r2 then R-type rs=2
        step(1, mk(1, 2, 1, 0, 4), 0, 0, 0, 0);
        step(1, mk(0, 6, 2, 3, 0), 0, 0, 0, 0);
        check("stall_bubble", {31'b0, ex_valid}, 0);
        step(1, mk(0, 6, 2, 3, 0), 0, 0, 0, 0);
        check("stall_issue", {31'b0, ex_valid}, 1);
        check("stall_cnt_1", {16'b0, stall_cnt}, 1);

        // Hazard with flush: no stall, bubble, count unchanged
        step(1, mk(1, 2, 1, 0, 4), 0, 0, 0, 0);
        step(1, mk(0, 6, 2, 3, 0), 1, 0, 0, 0);
        check("flush_bubble", {31'b0, ex_valid}, 0);
        check("flush_cnt", {16'b0, stall_cnt}, 1);

        // Reset asserted in the middle of a stall cycle takes effect without a clock edge
        step(1, mk(1, 2, 1, 0, 4), 0, 0, 0, 0);
        @(negedge clk);
        if_valid = 1; if_instr = mk(0, 6, 2, 3, 0); flush = 0; wb_en = 0;
        #1;
        check("pre_reset_stall", {31'b0, id_ready}, 0);
        rst = 1'b0;
        #1;
        check("async_id_ready", {31'b0, id_ready}, 1);
        check("async_ex_valid", {31'b0, ex_valid}, 0);
        check("async_memread", {31'b0, ex_memread}, 0);
        check("async_stall_cnt", {16'b0, stall_cnt}, 0);
        check("async_ex_rd", {28'b0, ex_rd}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1, mk(0, 7, 3, 1, 0), 0, 0, 0, 0);
        check("post_reset_regs", ex_rd1 | ex_rd2, 0);

        // Randomized traffic over a small register set so hazards and bypasses are frequent
        ins = 0;
        for (int n = 0; n < 1500; n++) begin
            if (last_stall) begin
                v = 1;
            end else begin
                v   = ($urandom_range(0, 99) < 85);
                ins = mk($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 16'hFFFF));
            end
            fl = ($urandom_range(0, 99) < 10);
            we = ($urandom_range(0, 1) == 1);
            step(v, ins, fl, we, 4'($urandom_range(0, 3)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
